apb_slave_mem: RTL and testbench

- Parametrised APB slave responder: a word-addressed memory window for the NOC APB slave ports (S0..Sn).
- Generalises the fixed 32-bit, pin-only slave port with configurable data/address width, depth, base address and wait states.
- Adds byte strobes, error responses and transfer counters.
- Connects to one APB slave port of the fabric. Used as RTL endpoint and as a reference responder in the UVM env.

---
 rtl/apb_slave_pkg.sv | 27 ++
 rtl/apb_slave_ram.sv | 39 +++
 rtl/apb_slave_mem.sv | 169 ++++++++++++++++
 tb/tb_apb_slave_mem.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/apb_slave_pkg.sv
// rtl/apb_slave_pkg.sv - shared types and width helpers for the APB memory slave
package apb_slave_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} apb_st_e;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 256;

  function automatic int strb_width(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int off_width(input int strb_w);
    return (strb_w > 1) ? $clog2(strb_w) : 0;
  endfunction

  // 64-bit compare so base + span cannot overflow the bus address width
  function automatic logic addr_in_range(input logic [63:0] addr, input logic [63:0] base,
                                         input logic [63:0] span);
    return (addr >= base) && ((addr - base) < span);
  endfunction

endpackage

// File: rtl/apb_slave_ram.sv
// rtl/apb_slave_ram.sv - single-port byte-enable synchronous RAM with registered read port
module apb_slave_ram
  import apb_slave_pkg::*;
#(
  parameter int  DEPTH  = DEF_DEPTH,
  parameter int  DATA_W = DEF_DATA_W,
  localparam int STRB_W = strb_width(DATA_W),
  localparam int IDX_W  = idx_width(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [IDX_W-1:0]  addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [STRB_W-1:0] strb_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (strb_i[i]) mem_q[addr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
      end
    end
  end

  // Read register returns to zero whenever no read is issued, so it can drive the bus directly.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || !re_i) rdata_q <= '0;
    else                  rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/apb_slave_mem.sv
// rtl/apb_slave_mem.sv - APB slave word memory with wait states, error decode and counters
module apb_slave_mem
  import apb_slave_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = DEF_DATA_W,
  parameter int                DEPTH     = DEF_DEPTH,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                MAX_WAIT  = 15,
  parameter int                CNT_W     = 16,
  localparam int               STRB_W    = strb_width(DATA_W),
  localparam int               IDX_W     = idx_width(DEPTH),
  localparam int               OFF_W     = off_width(STRB_W),
  localparam int               WAIT_W    = $clog2(MAX_WAIT + 1)
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  input  logic [STRB_W-1:0] PSTRB,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  input  logic [WAIT_W-1:0] cfg_wait,
  output logic [CNT_W-1:0]  xfer_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  apb_st_e           state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] strb_q, strb_d;
  logic              write_q, write_d;
  logic              err_q, err_d;
  logic [WAIT_W-1:0] wcnt_q, wcnt_d;
  logic              pready_q, pready_d;
  logic              pslverr_q, pslverr_d;
  logic [CNT_W-1:0]  xfer_q, xfer_d;
  logic [CNT_W-1:0]  errc_q, errc_d;

  logic [ADDR_W-1:0] paddr_off;
  logic [IDX_W-1:0]  paddr_idx;
  logic              setup_err;
  logic [WAIT_W-1:0] wait_init;
  logic              setup;
  logic              take_setup, enter_resp, resp_err, resp_write;
  logic              ram_we, ram_re;
  logic [IDX_W-1:0]  ram_addr;

  assign paddr_off = PADDR - BASE_ADDR;
  assign paddr_idx = IDX_W'(paddr_off >> OFF_W);
  assign setup_err = !addr_in_range(64'(PADDR), 64'(BASE_ADDR), 64'(DEPTH * STRB_W))
                     || ((paddr_off & ADDR_W'(STRB_W - 1)) != '0);
  assign wait_init = (int'(cfg_wait) > MAX_WAIT) ? WAIT_W'(MAX_WAIT) : cfg_wait;
  assign setup     = PSEL && !PENABLE;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    strb_d     = strb_q;
    write_d    = write_q;
    err_d      = err_q;
    wcnt_d     = wcnt_q;
    take_setup = 1'b0;
    enter_resp = 1'b0;
    resp_err   = err_q;
    resp_write = write_q;

    case (state_q)
      IDLE: take_setup = setup;
      WAIT: begin
        if (!PSEL)                         state_d = IDLE;
        else if (setup)                    take_setup = 1'b1;
        else if (wcnt_q == WAIT_W'(1)) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else                           wcnt_d = wcnt_q - WAIT_W'(1);
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A setup seen in WAIT restarts the transfer exactly as one seen in IDLE.
    if (take_setup) begin
      idx_d      = paddr_idx;
      wdata_d    = PWDATA;
      strb_d     = PSTRB;
      write_d    = PWRITE;
      err_d      = setup_err;
      wcnt_d     = wait_init;
      resp_err   = setup_err;
      resp_write = PWRITE;
      if (wait_init == '0) begin
        state_d    = RESP;
        enter_resp = 1'b1;
      end else begin
        state_d    = WAIT;
      end
    end

    pready_d  = enter_resp;
    pslverr_d = enter_resp && resp_err;
    ram_re    = enter_resp && !resp_err && !resp_write;
    ram_we    = (state_q == RESP) && write_q && !err_q && ARESETn;
    ram_addr  = take_setup ? paddr_idx : idx_q;

    xfer_d = xfer_q;
    errc_d = errc_q;
    if (state_q == RESP) begin
      if (err_q) begin
        if (errc_q != '1) errc_d = errc_q + CNT_W'(1);
      end else if (xfer_q != '1) begin
        xfer_d = xfer_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      write_q   <= 1'b0;
      err_q     <= 1'b0;
      wcnt_q    <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      xfer_q    <= '0;
      errc_q    <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      write_q   <= write_d;
      err_q     <= err_d;
      wcnt_q    <= wcnt_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      xfer_q    <= xfer_d;
      errc_q    <= errc_d;
    end
  end

  apb_slave_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk_i   (ACLK),
    .rst_ni  (ARESETn),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .addr_i  (ram_addr),
    .wdata_i (wdata_q),
    .strb_i  (strb_q),
    .rdata_o (PRDATA)
  );

  assign PREADY   = pready_q;
  assign PSLVERR  = pslverr_q;
  assign xfer_cnt = xfer_q;
  assign err_cnt  = errc_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// tb/tb_apb_slave_mem.sv - directed self-checking bench for apb_slave_mem
module tb_apb_slave_mem;

  localparam int          DEPTH = 64;
  localparam logic [31:0] B     = 32'h0000_1000;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic [3:0]  PSTRB;
  logic        PREADY, PSLVERR;
  logic [2:0]  cfg_wait;
  logic [3:0]  xfer_cnt, err_cnt;

  int n_checks = 0;
  int n_errors = 0;

  apb_slave_mem #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .DEPTH     (DEPTH),
    .BASE_ADDR (B),
    .MAX_WAIT  (6),
    .CNT_W     (4)
  ) dut (
    .ACLK     (ACLK),
    .ARESETn  (ARESETn),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PWRITE   (PWRITE),
    .PADDR    (PADDR),
    .PWDATA   (PWDATA),
    .PSTRB    (PSTRB),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY),
    .PSLVERR  (PSLVERR),
    .cfg_wait (cfg_wait),
    .xfer_cnt (xfer_cnt),
    .err_cnt  (err_cnt)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic begin_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int w);
    PSEL     = 1'b1;
    PENABLE  = 1'b0;
    PWRITE   = wr;
    PADDR    = addr;
    PWDATA   = data;
    PSTRB    = strb;
    cfg_wait = 3'(w);
    @(posedge ACLK); #1;
    PENABLE  = 1'b1;
  endtask

  task automatic finish_xfer(output logic [31:0] rdata, output logic err, output int acc);
    acc   = 0;
    rdata = '0;
    err   = 1'b0;
    PENABLE = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      if (PREADY) begin
        acc   = c;
        rdata = PRDATA;
        err   = PSLVERR;
        break;
      end
      @(posedge ACLK); #1;
    end
    if (acc == 0) check("ready_timeout", 32'd0, 32'd1);
    @(posedge ACLK); #1;
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    if (acc != 0) begin
      check("pready_one_cycle", {31'd0, PREADY}, 32'd0);
      check("prdata_cleared", PRDATA, 32'd0);
    end
  endtask

  task automatic xfer_chk(input string tag, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] strb, input int w,
                          input logic exp_err, input logic [31:0] exp_rdata, input int exp_acc);
    logic [31:0] rd;
    logic        err;
    int          acc;
    begin_xfer(wr, addr, data, strb, w);
    finish_xfer(rd, err, acc);
    check({tag, "_pslverr"}, {31'd0, err}, {31'd0, exp_err});
    if (!wr) check({tag, "_prdata"}, rd, exp_rdata);
    check({tag, "_latency"}, acc, exp_acc);
  endtask

  initial begin
    ARESETn = 1'b0;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; PSTRB = '0; cfg_wait = '0;
    repeat (2) @(posedge ACLK);
    #1;
    check("rst_pready", {31'd0, PREADY}, 32'd0);
    check("rst_pslverr", {31'd0, PSLVERR}, 32'd0);
    check("rst_prdata", PRDATA, 32'd0);
    check("rst_xfer", {28'd0, xfer_cnt}, 32'd0);
    check("rst_err", {28'd0, err_cnt}, 32'd0);
    ARESETn = 1'b1;

    // basic write / readback, zero wait states
    xfer_chk("wr_dead", 1'b1, B + 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0, 32'h0, 1);
    xfer_chk("rd_dead", 1'b0, B + 32'h10, 32'h0, 4'h0, 0, 1'b0, 32'hDEADBEEF, 1);
    check("xfer_after_2", {28'd0, xfer_cnt}, 32'd2);

    // three wait states: PREADY in the fourth access cycle
    xfer_chk("wr_w0", 1'b1, B, 32'h0BADF00D, 4'hF, 0, 1'b0, 32'h0, 1);
    xfer_chk("rd_w3", 1'b0, B, 32'h0, 4'h0, 3, 1'b0, 32'h0BADF00D, 4);

    // byte strobes
    xfer_chk("wr_ones", 1'b1, B + 32'h20, 32'hFFFFFFFF, 4'hF, 0, 1'b0, 32'h0, 1);
    xfer_chk("wr_strb5", 1'b1, B + 32'h20, 32'h00000000, 4'b0101, 1, 1'b0, 32'h0, 2);
    xfer_chk("rd_strb", 1'b0, B + 32'h20, 32'h0, 4'h0, 0, 1'b0, 32'hFF00FF00, 1);
    xfer_chk("wr_strb0", 1'b1, B + 32'h20, 32'h11111111, 4'h0, 0, 1'b0, 32'h0, 1);
    xfer_chk("rd_strb0", 1'b0, B + 32'h20, 32'h0, 4'h0, 0, 1'b0, 32'hFF00FF00, 1);
    check("xfer_after_9", {28'd0, xfer_cnt}, 32'd9);

    // error decode: past the top, misaligned, below base
    xfer_chk("wr_top", 1'b1, B + DEPTH * 4, 32'h55555555, 4'hF, 0, 1'b1, 32'h0, 1);
    xfer_chk("wr_misal", 1'b1, B + 32'h2, 32'h55555555, 4'hF, 0, 1'b1, 32'h0, 1);
    check("err_after_2", {28'd0, err_cnt}, 32'd2);
    xfer_chk("rd_top", 1'b0, B + DEPTH * 4, 32'h0, 4'h0, 0, 1'b1, 32'h0, 1);
    xfer_chk("rd_below", 1'b0, B - 32'h4, 32'h0, 4'h0, 2, 1'b1, 32'h0, 3);
    check("err_after_4", {28'd0, err_cnt}, 32'd4);
    check("xfer_after_err", {28'd0, xfer_cnt}, 32'd9);
    xfer_chk("rd_w0_keep", 1'b0, B, 32'h0, 4'h0, 0, 1'b0, 32'h0BADF00D, 1);
    xfer_chk("rd_w4_keep", 1'b0, B + 32'h10, 32'h0, 4'h0, 0, 1'b0, 32'hDEADBEEF, 1);

    // cfg_wait above MAX_WAIT is clamped to 6
    xfer_chk("rd_clamp", 1'b0, B + 32'h10, 32'h0, 4'h0, 7, 1'b0, 32'hDEADBEEF, 7);
    check("xfer_after_12", {28'd0, xfer_cnt}, 32'd12);

    // abort: PSEL dropped during WAIT
    begin_xfer(1'b1, B + 32'h10, 32'h12345678, 4'hF, 5);
    repeat (2) begin
      check("abort_wait_ready", {31'd0, PREADY}, 32'd0);
      @(posedge ACLK); #1;
    end
    PSEL = 1'b0; PENABLE = 1'b0;
    repeat (8) begin
      @(posedge ACLK); #1;
      check("abort_idle_ready", {31'd0, PREADY}, 32'd0);
    end
    check("abort_xfer", {28'd0, xfer_cnt}, 32'd12);
    check("abort_err", {28'd0, err_cnt}, 32'd4);
    xfer_chk("rd_after_abort", 1'b0, B + 32'h10, 32'h0, 4'h0, 0, 1'b0, 32'hDEADBEEF, 1);

    // new setup during WAIT replaces the pending write
    begin_xfer(1'b1, B + 32'h10, 32'h12345678, 4'hF, 5);
    @(posedge ACLK); #1;
    xfer_chk("resetup_rd", 1'b0, B + 32'h20, 32'h0, 4'h0, 0, 1'b0, 32'hFF00FF00, 1);
    xfer_chk("rd_after_resetup", 1'b0, B + 32'h10, 32'h0, 4'h0, 0, 1'b0, 32'hDEADBEEF, 1);
    check("xfer_after_15", {28'd0, xfer_cnt}, 32'd15);

    // reset pulse during WAIT
    begin_xfer(1'b1, B, 32'h00000000, 4'hF, 5);
    @(posedge ACLK); #1;
    ARESETn = 1'b0;
    @(posedge ACLK); #1;
    ARESETn = 1'b1;
    PSEL = 1'b0; PENABLE = 1'b0;
    check("midrst_pready", {31'd0, PREADY}, 32'd0);
    check("midrst_pslverr", {31'd0, PSLVERR}, 32'd0);
    check("midrst_xfer", {28'd0, xfer_cnt}, 32'd0);
    check("midrst_err", {28'd0, err_cnt}, 32'd0);
    xfer_chk("rd_after_rst", 1'b0, B, 32'h0, 4'h0, 2, 1'b0, 32'h0BADF00D, 3);
    check("xfer_after_rst", {28'd0, xfer_cnt}, 32'd1);

    // saturation of the 4-bit transfer counter
    repeat (16) xfer_chk("sat_rd", 1'b0, B + 32'h10, 32'h0, 4'h0, 0, 1'b0, 32'hDEADBEEF, 1);
    check("xfer_saturated", {28'd0, xfer_cnt}, 32'd15);
    check("err_still_zero", {28'd0, err_cnt}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
